apb_req_arbiter: RTL

//  Shares the single APB master (APB_Protocol) between N_REQ requesters, e.g. GPIO and UART drivers.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/apb_req_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter and related bus bridges.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic APB_READ  = 1'b1;
  localparam logic APB_WRITE = 1'b0;

  // Slave select is the address MSB: 0 = slave1, 1 = slave2.
  function automatic logic slave_sel(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] s;
    s = addr >> (addr_w - 1);
    return s[0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req scanning pointer+1 .. pointer (mod N).
// Zero latency, no state; the caller owns the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so that bit 0 of rot is the requester just after the pointer.
  always_comb begin
    dbl = {req, req} >> (32'(pointer) + 32'd1);
    rot = dbl[N-1:0];
  end

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        index = IW'((int'(pointer) + 1 + i) % N);
      end
    end
    if (valid) grant = N'(1) << index;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin share of one APB master among N_REQ requesters; 2 edges min req->ack, one txn in flight.
// Requesters hold req until ack; watchdog aborts a transfer after TIMEOUT cycles (0 = off).
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic                      apb_done,
  input  logic [DATA_W-1:0]         apb_read_data_out,
  input  logic                      PSLVERR
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [N_REQ-1:0]  gnt_oh;

  logic [N_REQ-1:0]  win_grant;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              timeout_hit;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req     (req),
    .pointer (ptr),
    .grant   (win_grant),
    .index   (win_idx),
    .valid   (win_vld)
  );

  always_comb begin
    win_addr    = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_wdata   = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
    timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state           <= IDLE;
      ptr             <= IW'(N_REQ - 1);
      cnt             <= '0;
      gnt_oh          <= '0;
      req_ack         <= '0;
      req_rdata       <= '0;
      req_err         <= 1'b0;
      grant_id        <= '0;
      busy            <= 1'b0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b0;
      apb_write_paddr <= '0;
      apb_write_data  <= '0;
      apb_read_paddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= XFER;
            busy     <= 1'b1;
            transfer <= 1'b1;
            grant_id <= win_idx;
            ptr      <= win_idx;
            gnt_oh   <= win_grant;
            cnt      <= '0;
            if (req_write[win_idx]) begin
              READ_WRITE      <= APB_WRITE;
              apb_write_paddr <= win_addr;
              apb_write_data  <= win_wdata;
              apb_read_paddr  <= '0;
            end else begin
              READ_WRITE      <= APB_READ;
              apb_read_paddr  <= win_addr;
              apb_write_paddr <= '0;
              apb_write_data  <= '0;
            end
          end
        end
        XFER: begin
          cnt <= cnt + 1'b1;
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (apb_done) begin
            state     <= RESP;
            transfer  <= 1'b0;
            req_ack   <= gnt_oh;
            req_rdata <= (READ_WRITE == APB_READ) ? apb_read_data_out : '0;
            req_err   <= PSLVERR;
          end else if (timeout_hit) begin
            state     <= RESP;
            transfer  <= 1'b0;
            req_ack   <= gnt_oh;
            req_rdata <= '0;
            req_err   <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ack   <= '0;
          req_rdata <= '0;
          req_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
